// File: rtl/user_edge_pkg.sv
// Shared definitions for the user-domain Sobel edge engine: register offsets,
// control/status bit positions, FSM state encoding, gradient/magnitude widths
// and the OBI request/response structures used by the default build.
package user_edge_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_REGION = 3'd2;
  localparam logic [2:0] REG_THRESH = 3'd3;
  localparam logic [2:0] REG_SUM    = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_IRQEN = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_RGN_ERR = 2;
  localparam int STAT_SAT     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOAD,
    ST_CALC,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Signed gradient width: 4*max_pixel needs two extra bits plus sign plus headroom.
  function automatic int grad_w(input int pix_w);
    return pix_w + 4;
  endfunction

  // Unsigned magnitude width: |gx|+|gy| <= 8*max_pixel.
  function automatic int mag_w(input int pix_w);
    return pix_w + 3;
  endfunction

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aid;
  } edge_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        rid;
  } edge_obi_rsp_t;

endpackage

// File: rtl/user_sobel_core.sv
// Combinational 3x3 Sobel magnitude: mag = |gx| + |gy|.
// Window is indexed win[col][row]; col 0 is the left column, row 0 the top row.
module user_sobel_core
  import user_edge_pkg::*;
#(
  parameter int PixW = 8
) (
  input  logic [PixW-1:0]        win [3][3],
  output logic [mag_w(PixW)-1:0] mag
);

  localparam int GW = grad_w(PixW);
  localparam int MW = mag_w(PixW);

  logic signed [GW-1:0] p [3][3];
  logic signed [GW-1:0] gx;
  logic signed [GW-1:0] gy;
  logic [MW-1:0]        abs_gx;
  logic [MW-1:0]        abs_gy;

  // Zero-extend pixels into the signed gradient domain, then apply both kernels.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        p[c][r] = $signed(GW'(win[c][r]));
      end
    end
    gx = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
    gy = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    abs_gx = gx[GW-1] ? MW'(-gx) : MW'(gx);
    abs_gy = gy[GW-1] ? MW'(-gy) : MW'(gy);
    mag    = abs_gx + abs_gy;
  end

endmodule

// File: rtl/user_edge_engine.sv
// OBI-mapped Sobel edge engine: sweeps a rectangle of 3x3 windows over a ROM image,
// accumulating a saturating magnitude sum and a count of windows above threshold.
// Columns are reused: 9 ROM reads for the first window of a row, 3 per step after.
// Optional feature macro: USER_EDGE_IRQ_EN (done interrupt gated by CTRL.IRQEN).
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | validate the programmed region
// LOAD   | fetch full 3x3 window for the first centre of a row (9 reads)
// CALC   | accumulate magnitude of the current window
// SHIFT  | slide window right, fetch the new right column (3 reads)
// DONE   | flag completion for one cycle
module user_edge_engine
  import user_edge_pkg::*;
#(
  parameter type         obi_req_t = edge_obi_req_t,
  parameter type         obi_rsp_t = edge_obi_rsp_t,
  parameter int          PixW      = 8,
  parameter int          ImgW      = 64,
  parameter int          ImgH      = 64,
  parameter logic [31:0] RomBase   = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  obi_req_t        obi_req_i,
  output obi_rsp_t        obi_rsp_o,
  output logic            rom_req_o,
  output logic [31:0]     rom_addr_o,
  input  logic [PixW-1:0] rom_data_i,
  input  logic            rom_valid_i,
  output logic            irq_o
);

  localparam int MW = mag_w(PixW);

  state_e          state, state_nxt;
  logic [7:0]      cx, cy;
  logic [1:0]      rd_row, rd_col;
  logic [PixW-1:0] win [3][3];
  logic [MW-1:0]   mag;
  logic [MW-1:0]   thresh;
  logic [31:0]     region, sum, count;
  logic            done, rgn_err, sat;
  logic            rsp_valid, rsp_err, rsp_rid;
  logic [31:0]     rsp_rdata;
  logic [32:0]     sum_ext;
  logic [31:0]     ctrl_rd;
  logic [31:0]     ay, ax;
`ifdef USER_EDGE_IRQ_EN
  logic            irqen;
`endif

  logic [7:0] x0, y0, x1, y1;
  logic [2:0] reg_sel;
  logic       wr, start_cmd, abort_cmd, busy, rom_fire, region_bad;
  logic       unused_bits;

  assign x0 = region[7:0];
  assign y0 = region[15:8];
  assign x1 = region[23:16];
  assign y1 = region[31:24];

  assign reg_sel    = obi_req_i.addr[4:2];
  assign wr         = obi_req_i.req && obi_req_i.we;
  assign start_cmd  = wr && (reg_sel == REG_CTRL) && obi_req_i.wdata[CTRL_START];
  assign abort_cmd  = wr && (reg_sel == REG_CTRL) && obi_req_i.wdata[CTRL_ABORT];
  assign busy       = (state != ST_IDLE);
  assign rom_fire   = rom_req_o && rom_valid_i;
  assign sum_ext    = {1'b0, sum} + 33'(mag);
  assign region_bad = (x0 < 8'd1) || (y0 < 8'd1) ||
                      (32'(x1) > 32'(ImgW - 2)) || (32'(y1) > 32'(ImgH - 2)) ||
                      (x0 > x1) || (y0 > y1);

  // Byte enables and untranslated address bits have no function here.
  assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[31:5], obi_req_i.addr[1:0]};

`ifdef USER_EDGE_IRQ_EN
  assign ctrl_rd = 32'(irqen) << CTRL_IRQEN;
  assign irq_o   = done & irqen;
`else
  assign ctrl_rd = 32'h0;
  assign irq_o   = 1'b0;
`endif

  user_sobel_core #(.PixW(PixW)) u_sobel (
    .win (win),
    .mag (mag)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state; abort overrides everything while busy.
  always_comb begin
    state_nxt = state;
    if (abort_cmd && busy) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_cmd) state_nxt = ST_CHECK;
        ST_CHECK: state_nxt = region_bad ? ST_IDLE : ST_LOAD;
        ST_LOAD:  if (rom_fire && rd_row == 2'd2 && rd_col == 2'd2) state_nxt = ST_CALC;
        ST_CALC: begin
          if (cx < x1)      state_nxt = ST_SHIFT;
          else if (cy < y1) state_nxt = ST_LOAD;
          else              state_nxt = ST_DONE;
        end
        ST_SHIFT: if (rom_fire && rd_row == 2'd2) state_nxt = ST_CALC;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: ROM request and address, held stable from the read counters.
  always_comb begin
    rom_req_o  = (state == ST_LOAD) || (state == ST_SHIFT);
    ay         = 32'(cy) - 32'd1 + 32'(rd_row);
    ax         = (state == ST_SHIFT) ? 32'(cx) + 32'd1 : 32'(cx) - 32'd1 + 32'(rd_col);
    rom_addr_o = RomBase + ay * 32'(ImgW) + ax;
  end

  // Bus response: grant is immediate, data/err/rid follow one cycle later.
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rsp_valid;
    obi_rsp_o.rdata  = rsp_rdata;
    obi_rsp_o.err    = rsp_err;
    obi_rsp_o.rid    = rsp_rid;
  end

  // Scan datapath: centre counters, window buffer, accumulators and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cx <= '0; cy <= '0; rd_row <= '0; rd_col <= '0;
      sum <= '0; count <= '0; done <= 1'b0; rgn_err <= 1'b0; sat <= 1'b0;
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++) win[c][r] <= '0;
    end else begin
      if (wr && reg_sel == REG_STATUS) begin
        if (obi_req_i.wdata[STAT_DONE])    done    <= 1'b0;
        if (obi_req_i.wdata[STAT_RGN_ERR]) rgn_err <= 1'b0;
        if (obi_req_i.wdata[STAT_SAT])     sat     <= 1'b0;
      end
      if (!(abort_cmd && busy)) begin
        case (state)
          ST_IDLE: if (start_cmd) begin
            sum <= '0; count <= '0; done <= 1'b0; rgn_err <= 1'b0; sat <= 1'b0;
            cx <= x0; cy <= y0; rd_row <= '0; rd_col <= '0;
          end
          ST_CHECK: if (region_bad) begin
            rgn_err <= 1'b1;
            done    <= 1'b1;
          end
          ST_LOAD: if (rom_fire) begin
            win[rd_col][rd_row] <= rom_data_i;
            if (rd_row == 2'd2) begin
              rd_row <= '0;
              rd_col <= (rd_col == 2'd2) ? 2'd0 : rd_col + 2'd1;
            end else begin
              rd_row <= rd_row + 2'd1;
            end
          end
          ST_CALC: begin
            if (sum_ext[32]) begin
              sum <= 32'hFFFF_FFFF;
              sat <= 1'b1;
            end else begin
              sum <= sum_ext[31:0];
            end
            if (mag > thresh) count <= count + 32'd1;
            rd_row <= '0;
            if (cx < x1) begin
              cx <= cx + 8'd1;
              for (int r = 0; r < 3; r++) begin
                win[0][r] <= win[1][r];
                win[1][r] <= win[2][r];
              end
            end else if (cy < y1) begin
              cy     <= cy + 8'd1;
              cx     <= x0;
              rd_col <= '0;
            end
          end
          ST_SHIFT: if (rom_fire) begin
            win[2][rd_row] <= rom_data_i;
            rd_row <= (rd_row == 2'd2) ? 2'd0 : rd_row + 2'd1;
          end
          ST_DONE: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Register file: configuration writes and registered read responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      region <= '0; thresh <= '0;
      rsp_valid <= 1'b0; rsp_err <= 1'b0; rsp_rid <= 1'b0; rsp_rdata <= '0;
`ifdef USER_EDGE_IRQ_EN
      irqen <= 1'b0;
`endif
    end else begin
      rsp_valid <= obi_req_i.req;
      rsp_rid   <= obi_req_i.aid;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      if (obi_req_i.req) begin
        case (reg_sel)
          REG_CTRL: begin
            if (!obi_req_i.we) rsp_rdata <= ctrl_rd;
`ifdef USER_EDGE_IRQ_EN
            else irqen <= obi_req_i.wdata[CTRL_IRQEN];
`endif
          end
          REG_STATUS: if (!obi_req_i.we) rsp_rdata <= {28'h0, sat, rgn_err, done, busy};
          REG_REGION: begin
            if (!obi_req_i.we) rsp_rdata <= region;
            else if (busy)     rsp_err   <= 1'b1;
            else               region    <= obi_req_i.wdata;
          end
          REG_THRESH: begin
            if (!obi_req_i.we) rsp_rdata <= 32'(thresh);
            else if (busy)     rsp_err   <= 1'b1;
            else               thresh    <= obi_req_i.wdata[MW-1:0];
          end
          REG_SUM: begin
            if (obi_req_i.we) rsp_err   <= 1'b1;
            else              rsp_rdata <= sum;
          end
          REG_COUNT: begin
            if (obi_req_i.we) rsp_err   <= 1'b1;
            else              rsp_rdata <= count;
          end
          default: rsp_err <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_user_edge_engine.sv
// Self-checking bench for user_edge_engine on an 8x8, 8-bit image with a
// 1-cycle-latency ROM model and a plain-arithmetic Sobel reference.
module tb_user_edge_engine;
  import user_edge_pkg::*;

  localparam int PixW = 8;
  localparam int ImgW = 8;
  localparam int ImgH = 8;

  localparam int O_CTRL = 'h00, O_STATUS = 'h04, O_REGION = 'h08;
  localparam int O_THRESH = 'h0C, O_SUM = 'h10, O_COUNT = 'h14, O_BAD = 'h1C;

  localparam int K_RAND = 0, K_T1 = 1, K_FLAT = 2, K_BIN = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_obi_req_t   obi_req;
  edge_obi_rsp_t   obi_rsp;
  logic            rom_req;
  logic [31:0]     rom_addr;
  logic [PixW-1:0] rom_data;
  logic            rom_valid;
  logic            irq;

  logic [7:0] img [ImgW*ImgH];
  int n_checks = 0;
  int n_fail = 0;
  int rd_cnt = 0;
  int req_cyc = 0;
  logic [31:0] start_word = 32'h1;

  logic [31:0] res_status, res_sum, res_count;
  int res_reads, res_reqc, res_polls;

  typedef struct {
    int x0, y0, x1, y1, thr, kind;
    bit exp_err;
  } vec_t;
  vec_t vecs [12];

  user_edge_engine #(.PixW(PixW), .ImgW(ImgW), .ImgH(ImgH), .RomBase(32'h0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .obi_req_i   (obi_req),
    .obi_rsp_o   (obi_rsp),
    .rom_req_o   (rom_req),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .rom_valid_i (rom_valid),
    .irq_o       (irq)
  );

  // ROM answers each request one cycle after it is first seen.
  always @(posedge clk) begin
    if (rst) begin
      rom_valid <= 1'b0;
      rom_data  <= '0;
    end else if (rom_req && !rom_valid) begin
      rom_valid <= 1'b1;
      rom_data  <= (rom_addr < 32'(ImgW*ImgH)) ? img[rom_addr[5:0]] : 8'hEE;
    end else begin
      rom_valid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rom_req && rom_valid) rd_cnt <= rd_cnt + 1;
    if (rom_req) req_cyc <= req_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus(input bit we, input int off, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    logic aid;
    aid = 1'($urandom_range(0, 1));
    @(negedge clk);
    obi_req.req = 1'b1; obi_req.we = we; obi_req.be = 4'hF;
    obi_req.addr = 32'(off); obi_req.wdata = wdata; obi_req.aid = aid;
    #1 check("gnt", 32'(obi_rsp.gnt), 32'd1);
    @(posedge clk); #1;
    obi_req.req = 1'b0; obi_req.we = 1'b0;
    check("rvalid", 32'(obi_rsp.rvalid), 32'd1);
    check("rid", 32'(obi_rsp.rid), 32'(aid));
    rdata = obi_rsp.rdata;
    err   = obi_rsp.err;
  endtask

  task automatic wr(input int off, input logic [31:0] d, input bit exp_err);
    logic [31:0] rd_d; logic e;
    bus(1'b1, off, d, rd_d, e);
    check("wr_err", 32'(e), 32'(exp_err));
  endtask

  task automatic rd(input int off, output logic [31:0] d);
    logic e;
    bus(1'b0, off, 32'h0, d, e);
    check("rd_err", 32'(e), 32'd0);
  endtask

  function automatic int px(input int x, input int y);
    return int'(img[y*ImgW + x]);
  endfunction

  // Reference: direct Sobel sum over every centre of the rectangle.
  function automatic void model(input int x0, input int y0, input int x1, input int y1,
                                input int thr, output logic [31:0] s, output int c, output int r);
    longint acc = 0;
    c = 0;
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        int gx, gy, m;
        gx = px(x+1,y-1) + 2*px(x+1,y) + px(x+1,y+1) - px(x-1,y-1) - 2*px(x-1,y) - px(x-1,y+1);
        gy = px(x-1,y+1) + 2*px(x,y+1) + px(x+1,y+1) - px(x-1,y-1) - 2*px(x,y-1) - px(x+1,y-1);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        acc += m;
        if (m > thr) c++;
      end
    end
    s = (acc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(acc);
    r = (y1 - y0 + 1) * (9 + 3 * (x1 - x0));
  endfunction

  task automatic fill_img(input int kind);
    for (int i = 0; i < ImgW*ImgH; i++) begin
      case (kind)
        K_T1:    img[i] = ((i % ImgW) == 2) ? 8'd255 : 8'd0;
        K_FLAT:  img[i] = 8'h80;
        K_BIN:   img[i] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic wait_idle(input int max_polls);
    logic [31:0] st;
    res_polls = 0;
    do begin
      rd(O_STATUS, st);
      res_polls++;
    end while (st[STAT_BUSY] && res_polls < max_polls);
    check("idle_timeout", 32'(st[STAT_BUSY]), 32'd0);
  endtask

  task automatic run_scan(input int x0, input int y0, input int x1, input int y1, input int thr);
    int r0, q0;
    wr(O_REGION, {8'(y1), 8'(x1), 8'(y0), 8'(x0)}, 1'b0);
    wr(O_THRESH, 32'(thr), 1'b0);
    r0 = rd_cnt; q0 = req_cyc;
    wr(O_CTRL, start_word, 1'b0);
    wait_idle(1000);
    rd(O_STATUS, res_status);
    rd(O_SUM, res_sum);
    rd(O_COUNT, res_count);
    res_reads = rd_cnt - r0;
    res_reqc  = req_cyc - q0;
  endtask

  initial begin
    logic [31:0] d, exp_s;
    logic e;
    int exp_c, exp_r, base, guard;

    vecs[0]  = '{1, 1, 1, 1, 500,  K_T1,   1'b0};
    vecs[1]  = '{1, 1, 1, 1, 1020, K_T1,   1'b0};
    vecs[2]  = '{1, 1, 1, 1, 1019, K_T1,   1'b0};
    vecs[3]  = '{1, 1, 6, 6, 0,    K_FLAT, 1'b0};
    vecs[4]  = '{0, 1, 1, 1, 0,    K_RAND, 1'b1};
    vecs[5]  = '{1, 0, 1, 1, 0,    K_RAND, 1'b1};
    vecs[6]  = '{1, 1, 7, 1, 0,    K_RAND, 1'b1};
    vecs[7]  = '{1, 1, 1, 7, 0,    K_RAND, 1'b1};
    vecs[8]  = '{3, 1, 2, 1, 0,    K_RAND, 1'b1};
    vecs[9]  = '{1, 4, 1, 3, 0,    K_RAND, 1'b1};
    vecs[10] = '{6, 6, 6, 6, 300,  K_RAND, 1'b0};
    vecs[11] = '{1, 3, 6, 3, 200,  K_BIN,  1'b0};

    obi_req = '0;
    fill_img(K_FLAT);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rom_req", 32'(rom_req), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rvalid", 32'(obi_rsp.rvalid), 32'd0);
    rd(O_STATUS, d); check("rst_status", d, 32'h0);
    rd(O_SUM, d);    check("rst_sum", d, 32'h0);
    rd(O_COUNT, d);  check("rst_count", d, 32'h0);
    rd(O_REGION, d); check("rst_region", d, 32'h0);
    rd(O_CTRL, d);   check("ctrl_read", d, 32'h0);
    wr(O_THRESH, 32'hFFFF_FFFF, 1'b0);
    rd(O_THRESH, d); check("thresh_mask", d, 32'h7FF);
    wr(O_SUM, 32'h1, 1'b1);
    wr(O_COUNT, 32'h1, 1'b1);

    // Spec scenario: single window with a hard vertical edge.
    fill_img(K_T1);
    run_scan(1, 1, 1, 1, 500);
    check("t1_sum", res_sum, 32'd1020);
    check("t1_count", res_count, 32'd1);
    check("t1_reads", 32'(res_reads), 32'd9);
    check("t1_done", 32'(res_status[STAT_DONE]), 32'd1);

    // Spec scenario: flat image over the full legal region.
    fill_img(K_FLAT);
    run_scan(1, 1, 6, 6, 0);
    check("t2_sum", res_sum, 32'd0);
    check("t2_count", res_count, 32'd0);
    check("t2_reads", 32'(res_reads), 32'd144);
    check("t2_status", res_status, 32'h2);

    // Table of region/threshold vectors against the reference.
    for (int i = 0; i < 12; i++) begin
      fill_img(vecs[i].kind);
      model(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].thr, exp_s, exp_c, exp_r);
      run_scan(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].thr);
      check("vec_done", 32'(res_status[STAT_DONE]), 32'd1);
      check("vec_rgn_err", 32'(res_status[STAT_RGN_ERR]), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err) begin
        check("vec_err_reqcyc", 32'(res_reqc), 32'd0);
        check("vec_err_polls", 32'(res_polls <= 2), 32'd1);
        check("vec_err_sum", res_sum, 32'd0);
      end else begin
        check("vec_sum", res_sum, exp_s);
        check("vec_count", res_count, 32'(exp_c));
        check("vec_reads", 32'(res_reads), 32'(exp_r));
        check("vec_sat", 32'(res_status[STAT_SAT]), 32'd0);
      end
    end

    // Randomized regions, thresholds and images.
    for (int i = 0; i < 8; i++) begin
      int x0, y0, x1, y1, thr;
      x0 = $urandom_range(1, 6); x1 = $urandom_range(x0, 6);
      y0 = $urandom_range(1, 6); y1 = $urandom_range(y0, 6);
      thr = $urandom_range(0, 2047);
      fill_img(($urandom_range(0, 1) == 1) ? K_BIN : K_RAND);
      model(x0, y0, x1, y1, thr, exp_s, exp_c, exp_r);
      run_scan(x0, y0, x1, y1, thr);
      check("rnd_sum", res_sum, exp_s);
      check("rnd_count", res_count, 32'(exp_c));
      check("rnd_reads", 32'(res_reads), 32'(exp_r));
      check("rnd_status", res_status, 32'h2);
    end

    // Abort after 20 ROM reads.
    fill_img(K_RAND);
    wr(O_REGION, 32'h0606_0101, 1'b0);
    base = rd_cnt;
    wr(O_CTRL, 32'h1, 1'b0);
    guard = 0;
    while ((rd_cnt - base) < 20 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("abort_wait", 32'(guard < 500), 32'd1);
    wr(O_CTRL, 32'h2, 1'b0);
    check("abort_rom_req", 32'(rom_req), 32'd0);
    rd(O_STATUS, d);
    check("abort_busy", 32'(d[STAT_BUSY]), 32'd0);
    check("abort_done", 32'(d[STAT_DONE]), 32'd0);
    base = rd_cnt;
    repeat (5) @(negedge clk);
    check("abort_no_reads", 32'(rd_cnt - base), 32'd0);

    // Busy-time register protection, start-while-busy, illegal offset.
    fill_img(K_BIN);
    model(1, 1, 6, 6, 700, exp_s, exp_c, exp_r);
    wr(O_THRESH, 32'd700, 1'b0);
    wr(O_CTRL, 32'h1, 1'b0);
    wr(O_REGION, 32'h0101_0101, 1'b1);
    rd(O_REGION, d); check("busy_region_kept", d, 32'h0606_0101);
    wr(O_THRESH, 32'd5, 1'b1);
    rd(O_THRESH, d); check("busy_thresh_kept", d, 32'd700);
    wr(O_CTRL, 32'h1, 1'b0);
    bus(1'b0, O_BAD, 32'h0, d, e);
    check("bad_off_err", 32'(e), 32'd1);
    check("bad_off_rdata", d, 32'h0);
    bus(1'b1, O_BAD, 32'hFFFF_FFFF, d, e);
    check("bad_off_wr_err", 32'(e), 32'd1);
    wait_idle(1000);
    rd(O_SUM, d);   check("busy_sum", d, exp_s);
    rd(O_COUNT, d); check("busy_count", d, 32'(exp_c));

    // W1C of status bits.
    wr(O_STATUS, 32'h2, 1'b0);
    rd(O_STATUS, d); check("w1c_done", d, 32'h0);

    // Interrupt gating.
`ifdef USER_EDGE_IRQ_EN
    wr(O_CTRL, 32'h4, 1'b0);
    rd(O_CTRL, d); check("irqen_readback", d, 32'h4);
    start_word = 32'h5;
    fill_img(K_T1);
    run_scan(1, 1, 1, 1, 500);
    check("irq_high", 32'(irq), 32'd1);
    wr(O_STATUS, 32'h2, 1'b0);
    check("irq_low_after_w1c", 32'(irq), 32'd0);
    start_word = 32'h1;
`else
    wr(O_CTRL, 32'h4, 1'b0);
    rd(O_CTRL, d); check("irqen_ignored", d, 32'h0);
    fill_img(K_T1);
    run_scan(1, 1, 1, 1, 500);
    check("irq_tied", 32'(irq), 32'd0);
`endif

    // Reset in the middle of a scan.
    fill_img(K_RAND);
    wr(O_REGION, 32'h0606_0101, 1'b0);
    wr(O_CTRL, 32'h1, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rom_req", 32'(rom_req), 32'd0);
    rd(O_STATUS, d); check("midrst_status", d, 32'h0);
    rd(O_SUM, d);    check("midrst_sum", d, 32'h0);
    rd(O_REGION, d); check("midrst_region", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
